// File: rtl/imem_pkg.sv
// imem_pkg: definitions shared by the instruction-memory loader and the
// instruction memory itself.
//   state_t          - loader FSM state encoding
//   BYTES_PER_WORD   - bytes in one instruction word
//   IMEM_DEPTH_BYTES - instruction memory size; both sides must agree on it
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam int unsigned BYTES_PER_WORD   = 4;
  localparam int unsigned IMEM_DEPTH_BYTES = 81;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: writer side of the byte-addressed, little-endian instruction
// memory. Accepts 32-bit words from a boot/debug source and writes them one
// byte per cycle (lowest byte to lowest address), holding the core until the
// final word of the program has been written.
//
// Ports:
//   clk          - rising-edge clock
//   reset_n      - asynchronous active-low reset
//   start        - one-cycle pulse, begins a load at BASE_ADDR (IDLE/DONE/ERR)
//   word_valid   - source has a word
//   word_data    - instruction word
//   word_last    - marks word_data as the final word of the program
//   word_ready   - loader accepts a word this cycle
//   mem_we       - byte write strobe
//   mem_addr     - byte address
//   mem_wdata    - byte data
//   cpu_hold     - keeps the core stalled / in reset
//   done         - program loaded
//   error        - a word would have overflowed the memory
//   words_loaded - fully written words in the current load (saturating)
module imem_loader
  import imem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'd0,
  parameter int unsigned DEPTH_BYTES = IMEM_DEPTH_BYTES,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  input  logic             word_last,
  output logic             word_ready,
  output logic             mem_we,
  output logic [63:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  state_t      state;
  state_t      state_nxt;

  logic [63:0] addr_reg;
  logic [31:0] word_reg;
  logic        last_reg;
  logic [1:0]  byte_idx;
  logic [63:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;

  logic        word_fits;
  logic [63:0] wr_addr;
  logic [7:0]  wr_byte;

  // A word fits only if all four of its bytes land below DEPTH_BYTES.
  assign word_fits = (addr_reg + 64'(BYTES_PER_WORD)) <= 64'(DEPTH_BYTES);
  assign wr_addr   = addr_reg + 64'(byte_idx);
  assign wr_byte   = word_reg[{byte_idx, 3'b000} +: 8];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        // Handshake: word_ready is 1 throughout LOAD.
        if (word_valid) state_nxt = word_fits ? WRITE : ERR;
      end
      WRITE: begin
        if (byte_idx == 2'd3) state_nxt = last_reg ? DONE : LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: decoded from state and datapath registers only.
  // Outside WRITE the address/data buses replay the last byte written.
  always_comb begin
    word_ready = (state == LOAD);
    mem_we     = (state == WRITE);
    cpu_hold   = (state != DONE);
    done       = (state == DONE);
    error      = (state == ERR);
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    if (state == WRITE) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_byte;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg     <= BASE_ADDR;
      word_reg     <= '0;
      last_reg     <= 1'b0;
      byte_idx     <= '0;
      words_loaded <= '0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            addr_reg     <= BASE_ADDR;
            words_loaded <= '0;
          end
        end
        LOAD: begin
          if (word_valid && word_fits) begin
            word_reg <= word_data;
            last_reg <= word_last;
            byte_idx <= '0;
          end
        end
        WRITE: begin
          mem_addr_q  <= wr_addr;
          mem_wdata_q <= wr_byte;
          byte_idx    <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            addr_reg <= addr_reg + 64'(BYTES_PER_WORD);
            if (words_loaded != '1) words_loaded <= words_loaded + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed, table-driven bench for imem_loader plus
// hand-written sequences for backpressure, overflow and reset mid-word.
module tb_imem_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(
    .BASE_ADDR  (64'd0),
    .DEPTH_BYTES(81),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_last   (word_last),
    .word_ready  (word_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bus monitor: write log, handshake count, ready-during-write count.
  int          cyc = 0;
  int          hs_cnt = 0;
  int          viol_cnt = 0;
  logic [63:0] log_addr[$];
  logic [7:0]  log_data[$];
  bit          written[128];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      if (mem_addr < 64'd128) written[mem_addr[6:0]] = 1'b1;
    end
    if (word_valid && word_ready) hs_cnt = hs_cnt + 1;
    if (mem_we && word_ready) viol_cnt = viol_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!word_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!word_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: got 0, expected 1 within 20 cycles");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", done, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int hs_cyc;

  // Present one word, then check the four byte writes that follow.
  task automatic write_word(input logic [31:0] d, input logic last,
                            input logic [63:0] addr, input logic [0:3][7:0] b);
    wait_ready();
    word_valid = 1'b1;
    word_data  = d;
    word_last  = last;
    hs_cyc     = cyc;
    @(negedge clk);
    word_valid = 1'b0;
    word_last  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, addr + 64'(k));
      check("wr_data", mem_wdata, b[k]);
      check("wr_ready_low", word_ready, 0);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic            do_start;
    logic [31:0]     data;
    logic            last;
    logic [63:0]     addr;
    logic [0:3][7:0] b;
    logic            exp_done;
    logic [15:0]     exp_words;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int hs0_cyc;
    int hs_base;
    int log_base;
    int viol_base;

    vecs[0] = '{1'b1, 32'h00000513, 1'b0, 64'd0, {8'h13, 8'h05, 8'h00, 8'h00}, 1'b0, 16'd1};
    vecs[1] = '{1'b0, 32'h00000093, 1'b1, 64'd4, {8'h93, 8'h00, 8'h00, 8'h00}, 1'b1, 16'd2};
    vecs[2] = '{1'b1, 32'h12345678, 1'b0, 64'd0, {8'h78, 8'h56, 8'h34, 8'h12}, 1'b0, 16'd1};
    vecs[3] = '{1'b0, 32'hDEADBEEF, 1'b1, 64'd4, {8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b1, 16'd2};

    reset_n    = 1'b0;
    start      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    word_last  = 1'b0;
    hs0_cyc    = 0;

    // Reset state
    @(negedge clk);
    check("rst_we", mem_we, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_words", words_loaded, 0);
    check("rst_ready", word_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_ready", word_ready, 0);
    check("idle_hold", cpu_hold, 1);

    // Table: two-word load, then reload from DONE with two more words.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].do_start) begin
        pulse_start();
        check("start_ready", word_ready, 1);
        check("start_hold", cpu_hold, 1);
        check("start_done", done, 0);
        check("start_words", words_loaded, 0);
      end
      write_word(vecs[i].data, vecs[i].last, vecs[i].addr, vecs[i].b);
      if (i == 0) hs0_cyc = hs_cyc;
      check("vec_done", done, vecs[i].exp_done);
      check("vec_hold", cpu_hold, !vecs[i].exp_done);
      check("vec_words", words_loaded, vecs[i].exp_words);
      check("vec_we_off", mem_we, 0);
      if (i == 1) check("done_latency", 64'(cyc - hs0_cyc), 10);
    end
    check("hold_addr", mem_addr, 7);
    check("hold_wdata", mem_wdata, 8'hDE);

    // Backpressure: valid held high across three words.
    hs_base   = hs_cnt;
    log_base  = log_addr.size();
    viol_base = viol_cnt;
    pulse_start();
    word_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_ready();
      case (j)
        0: word_data = 32'hA3A2A1A0;
        1: word_data = 32'hB3B2B1B0;
        default: word_data = 32'hC3C2C1C0;
      endcase
      word_last = (j == 2);
      @(negedge clk);
    end
    wait_done();
    word_valid = 1'b0;
    word_last  = 1'b0;
    check("bp_handshakes", 64'(hs_cnt - hs_base), 3);
    check("bp_writes", 64'(log_addr.size() - log_base), 12);
    check("bp_ready_in_write", 64'(viol_cnt - viol_base), 0);
    check("bp_words", words_loaded, 3);
    check("bp_b4_addr", log_addr[log_base + 4], 4);
    check("bp_b4_data", log_data[log_base + 4], 8'hB0);
    check("bp_b11_addr", log_addr[log_base + 11], 11);
    check("bp_b11_data", log_data[log_base + 11], 8'hC3);

    // Overflow: 21 words without last into an 81-byte memory.
    hs_base  = hs_cnt;
    log_base = log_addr.size();
    pulse_start();
    word_valid = 1'b1;
    word_last  = 1'b0;
    for (int j = 0; j < 21; j++) begin
      wait_ready();
      word_data = 32'hAB000000 | 32'(j);
      @(negedge clk);
    end
    check("ovf_error", error, 1);
    check("ovf_hold", cpu_hold, 1);
    check("ovf_ready", word_ready, 0);
    check("ovf_words", words_loaded, 20);
    check("ovf_handshakes", 64'(hs_cnt - hs_base), 21);
    word_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_writes", 64'(log_addr.size() - log_base), 80);
    check("ovf_addr80", 64'(written[80]), 0);
    check("ovf_w19_addr", log_addr[log_base + 76], 76);
    check("ovf_w19_data", log_data[log_base + 76], 8'h13);
    check("ovf_last_addr", log_addr[log_base + 79], 79);
    check("ovf_last_data", log_data[log_base + 79], 8'hAB);
    check("ovf_sticky", error, 1);
    check("ovf_we_off", mem_we, 0);
    pulse_start();
    check("ovf_clear", error, 0);
    check("ovf_reload_ready", word_ready, 1);

    // Reset mid-word: two bytes of 0xFC411EE3 land, then reset.
    log_base   = log_addr.size();
    word_valid = 1'b1;
    word_data  = 32'hFC411EE3;
    @(negedge clk);
    word_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_hold", cpu_hold, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_words", words_loaded, 0);
    check("mid_rst_ready", word_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_writes", 64'(log_addr.size() - log_base), 2);
    check("mid_b0", {log_addr[log_base], 8'h00} | 64'(log_data[log_base]), {64'd0, 8'h00} | 64'hE3);
    check("mid_b1_addr", log_addr[log_base + 1], 1);
    check("mid_b1_data", log_data[log_base + 1], 8'h1E);
    @(negedge clk);
    check("mid_idle_ready", word_ready, 0);
    pulse_start();
    write_word(32'hCAFEF00D, 1'b1, 64'd0, {8'h0D, 8'hF0, 8'hFE, 8'hCA});
    check("mid_reload_done", done, 1);
    check("mid_reload_words", words_loaded, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
